arm_pipelined_uop_decoder: RTL and testbench
============================================

Name: arm_pipelined_uop_decoder

Overview:
Registered main decoder for the pipelined ARM core, successor to the combinational Decode-stage main decoder. It decodes Op/Funct into Execute-stage control and adds block transfer support (LDM/STM, increment-after). A block transfer is sequenced as one LDR/STR micro-op per listed register, with upstream fetch/decode stalled through a ready handshake. It sits between the Decode pipeline register and the Execute-stage control register, and replaces that register for the signals it drives.

Parameters:
NUM_REGS, 16, register-list width and register-file size.
REG_IDX_W, 4, register index width (clog2 NUM_REGS).
OFFS_W, 7, micro-op byte-offset width (holds NUM_REGS*4).

Ports:
i_CLK  in  1  core clock
i_RESET_N  in  1  asynchronous active-low reset
i_Valid  in  1  decode slot holds a valid instruction
i_Op  in  2  instr[27:26]
i_Funct  in  6  instr[25:20] (I, P/opc, U/opc, B/opc, W/opc, L/S)
i_Reg_List  in  NUM_REGS  instr[15:0] register list
i_Stall  in  1  hazard-unit stall of Execute register
i_Flush  in  1  hazard-unit flush (branch taken)
o_Ready  out  1  decoder can accept a new instruction this cycle
o_Valid_E  out  1  Execute-stage micro-op valid
o_Reg_Write_E, o_Mem_Write_E, o_Mem_To_Reg_E, o_ALU_Src_E, o_Branch_E, o_ALU_Op_E  out  1 each  Execute control
o_Reg_Src_E, o_Imm_Src_E  out  2 each  Execute source selects
o_Uop_Reg_E  out  REG_IDX_W  Rd/Rt of current block-transfer micro-op
o_Uop_Offs_E  out  OFFS_W  byte offset of micro-op from base
o_Uop_E  out  1  current micro-op comes from a block transfer (Rd = o_Uop_Reg_E)
o_Undef_E  out  1  undefined/unsupported instruction flagged

Behaviour:
- Reset (async, i_RESET_N=0): all outputs 0, FSM IDLE, internal list/counter 0. o_Ready=1 once reset is released.
- Accept = i_Valid & o_Ready & ~i_Stall. o_Ready is combinational: 1 in IDLE, 0 in SEQ.
- Latency: an instruction accepted in cycle N drives its control on the _E outputs in cycle N+1.
- Decode table, registered:
  - Op=00 (DP): ALU_Op=1, ALU_Src=Funct[5], Imm_Src=00, Reg_Src=00.
  - DP Reg_Write=1, except Reg_Write=0 when Funct[4:3]=10 and Funct[0]=1 (TST/TEQ/CMP/CMN).
  - Op=01 (MEM): Imm_Src=01, ALU_Src=~Funct[5].
  - MEM with L=1: Mem_To_Reg=1, Reg_Write=1, Reg_Src=00.
  - MEM with L=0: Mem_Write=1, Reg_Src=10.
  - Op=10 with Funct[5]=1 (B): Branch=1, Imm_Src=10, ALU_Src=1, Reg_Src=01.
  - Op=10 with Funct[5]=0 (block transfer): only P=0, U=1 (IA) is supported.
  - Block-transfer micro-op: Imm_Src=11, ALU_Src=1, o_Uop_E=1. L=1 gives LDR-like control; L=0 gives STR-like control with Reg_Src=10.
  - Op=11, or block transfer with P=1 or U=0: all write/branch controls 0, o_Undef_E=1, o_Valid_E=1.
- Sequencing:
  - k = popcount(i_Reg_List).
  - On accept of a block transfer with k>=2, emit micro-op 0 for the lowest set bit (offs 0), latch the remaining list, and go to SEQ.
  - In SEQ, each cycle with ~i_Stall emits the next lowest set bit. Offset advances by 4 for each micro-op.
  - Emission of the last micro-op returns the FSM to IDLE.
  - k=1: single micro-op, FSM stays IDLE.
  - k=0: one NOP micro-op (o_Valid_E=1, all writes 0), FSM stays IDLE.
- i_Stall=1: all _E outputs, FSM and latched list hold.
- i_Flush=1 (wins over stall and accept): next cycle o_Valid_E=0 and all writes 0. FSM goes to IDLE and latched list clears; remaining micro-ops are discarded.
- Not accepted and not in SEQ: o_Valid_E=0, controls 0.
- Reset mid-sequence: immediate return to IDLE, all outputs 0.

Optional Feature:
ARM_LDM_WRITEBACK_EN
- Defined: a block transfer with W=1 (Funct[1]) appends one extra micro-op after the last transfer.
  - Writeback micro-op controls: Reg_Write=1, ALU_Op=1, ALU_Src=1, Imm_Src=11, o_Uop_Offs_E=k*4, o_Uop_E=0 (Rd=Rn).
  - The k=1 case then also enters SEQ.
- Undefined: W is ignored; no writeback micro-op is emitted.

Test Plan:
- Reset: i_RESET_N=0 mid-cycle -> all outputs 0 immediately; o_Ready=1 after release.
- DP ADD imm (Op=00, Funct=101000) accepted -> next cycle Reg_Write=1, ALU_Src=1, ALU_Op=1. CMP (Funct=010101) -> Reg_Write=0.
- LDM IA, L=1, list=0x0025 -> 3 consecutive micro-ops, regs 0, 2, 5, offsets 0, 4, 8. o_Ready=0 for the 2 cycles after accept; FSM back in IDLE after the third micro-op.
- Same LDM with i_Stall=1 held for 2 cycles after the 2nd micro-op -> 2nd micro-op outputs held for 2 cycles, then reg 5 / offset 8 is emitted.
- STM list=0x00F0 with i_Flush=1 in the cycle after accept -> o_Valid_E=0 next cycle, o_Ready=1, no further micro-ops.
- With ARM_LDM_WRITEBACK_EN: LDM W=1, list=0x0003 -> regs 0, 1, then a writeback micro-op with offs 8, Reg_Write=1. Op=11 -> o_Undef_E=1, all writes 0.

Source files
------------

// File: rtl/arm_pipelined_uop_decoder.sv
// Registered ARM main decoder: DP/MEM/B decode plus LDM/STM (IA) expanded into LDR/STR micro-ops.
// Latency: an instruction accepted in cycle N drives its Execute control in cycle N+1; micro-ops follow one per unstalled cycle.
// Backpressure: o_Ready drops while a block transfer is being sequenced; i_Stall freezes everything; i_Flush clears and wins.
// Optional: define ARM_LDM_WRITEBACK_EN to append a base-writeback micro-op to block transfers with W=1.
module arm_pipelined_uop_decoder #(
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = 4,
  parameter int OFFS_W    = 7
) (
  input  logic                 i_CLK,
  input  logic                 i_RESET_N,
  input  logic                 i_Valid,
  input  logic [1:0]           i_Op,
  input  logic [5:0]           i_Funct,
  input  logic [NUM_REGS-1:0]  i_Reg_List,
  input  logic                 i_Stall,
  input  logic                 i_Flush,
  output logic                 o_Ready,
  output logic                 o_Valid_E,
  output logic                 o_Reg_Write_E,
  output logic                 o_Mem_Write_E,
  output logic                 o_Mem_To_Reg_E,
  output logic                 o_ALU_Src_E,
  output logic                 o_Branch_E,
  output logic                 o_ALU_Op_E,
  output logic [1:0]           o_Reg_Src_E,
  output logic [1:0]           o_Imm_Src_E,
  output logic [REG_IDX_W-1:0] o_Uop_Reg_E,
  output logic [OFFS_W-1:0]    o_Uop_Offs_E,
  output logic                 o_Uop_E,
  output logic                 o_Undef_E
);

  typedef struct packed {
    logic                 valid;
    logic                 reg_write;
    logic                 mem_write;
    logic                 mem_to_reg;
    logic                 alu_src;
    logic                 branch;
    logic                 alu_op;
    logic [1:0]           reg_src;
    logic [1:0]           imm_src;
    logic [REG_IDX_W-1:0] uop_reg;
    logic [OFFS_W-1:0]    uop_offs;
    logic                 uop;
    logic                 undef;
  } ctrl_t;

  typedef enum logic {S_IDLE, S_SEQ} state_t;

  state_t                r_state;
  ctrl_t                 r_ctrl;
  logic [NUM_REGS-1:0]   r_list;   // registers still to transfer
  logic [OFFS_W-1:0]     r_offs;   // byte offset of the next micro-op
  logic                  r_load;   // L bit of the block transfer in flight
  logic                  r_wb;     // base writeback micro-op still owed

  logic [NUM_REGS-1:0]   w_src_list;
  logic [NUM_REGS-1:0]   w_rest;
  logic [REG_IDX_W-1:0]  w_lo_idx;
  logic                  w_wb_req;
  ctrl_t                 w_dec;
  logic                  w_dec_seq;
  ctrl_t                 w_seq;
  logic                  w_unused;

`ifdef ARM_LDM_WRITEBACK_EN
  assign w_wb_req = i_Funct[1];
`else
  assign w_wb_req = 1'b0;
`endif

  // S bit is irrelevant to control decode; W only matters with writeback support
  assign w_unused = &{1'b0, i_Funct[2], i_Funct[1]};

  assign o_Ready    = (r_state == S_IDLE);
  assign w_src_list = (r_state == S_SEQ) ? r_list : i_Reg_List;
  // list with its lowest set bit removed
  assign w_rest     = w_src_list & (w_src_list - NUM_REGS'(1));

  // Lowest set register index of the list currently being consumed
  always_comb begin
    w_lo_idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (w_src_list[i]) w_lo_idx = REG_IDX_W'(i);
    end
  end

  // Decode of the instruction in the decode slot (used only when it is accepted)
  always_comb begin
    w_dec       = '0;
    w_dec.valid = 1'b1;
    w_dec_seq   = 1'b0;
    case (i_Op)
      2'b00: begin
        w_dec.alu_op    = 1'b1;
        w_dec.alu_src   = i_Funct[5];
        w_dec.reg_write = !((i_Funct[4:3] == 2'b10) && i_Funct[0]);
      end
      2'b01: begin
        w_dec.imm_src = 2'b01;
        w_dec.alu_src = ~i_Funct[5];
        if (i_Funct[0]) begin
          w_dec.mem_to_reg = 1'b1;
          w_dec.reg_write  = 1'b1;
        end else begin
          w_dec.mem_write = 1'b1;
          w_dec.reg_src   = 2'b10;
        end
      end
      2'b10: begin
        if (i_Funct[5]) begin
          w_dec.branch  = 1'b1;
          w_dec.imm_src = 2'b10;
          w_dec.alu_src = 1'b1;
          w_dec.reg_src = 2'b01;
        end else if (i_Funct[4] || !i_Funct[3]) begin
          w_dec.undef = 1'b1;
        end else if (i_Reg_List != '0) begin
          // first micro-op of the block transfer; an empty list stays a NOP
          w_dec.uop     = 1'b1;
          w_dec.imm_src = 2'b11;
          w_dec.alu_src = 1'b1;
          w_dec.uop_reg = w_lo_idx;
          if (i_Funct[0]) begin
            w_dec.mem_to_reg = 1'b1;
            w_dec.reg_write  = 1'b1;
          end else begin
            w_dec.mem_write = 1'b1;
            w_dec.reg_src   = 2'b10;
          end
          w_dec_seq = (w_rest != '0) || w_wb_req;
        end
      end
      default: begin
        w_dec.undef = 1'b1;
      end
    endcase
  end

  // Next micro-op while sequencing: a transfer, or the final base writeback
  always_comb begin
    w_seq          = '0;
    w_seq.valid    = 1'b1;
    w_seq.imm_src  = 2'b11;
    w_seq.alu_src  = 1'b1;
    w_seq.uop_offs = r_offs;
    if (r_list != '0) begin
      w_seq.uop     = 1'b1;
      w_seq.uop_reg = w_lo_idx;
      if (r_load) begin
        w_seq.mem_to_reg = 1'b1;
        w_seq.reg_write  = 1'b1;
      end else begin
        w_seq.mem_write = 1'b1;
        w_seq.reg_src   = 2'b10;
      end
    end else begin
      w_seq.reg_write = 1'b1;
      w_seq.alu_op    = 1'b1;
    end
  end

  // Sequencer FSM and registered Execute control; flush beats stall beats accept
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      r_state <= S_IDLE;
      r_ctrl  <= '0;
      r_list  <= '0;
      r_offs  <= '0;
      r_load  <= 1'b0;
      r_wb    <= 1'b0;
    end else if (i_Flush) begin
      r_state <= S_IDLE;
      r_ctrl  <= '0;
      r_list  <= '0;
      r_offs  <= '0;
      r_wb    <= 1'b0;
    end else if (!i_Stall) begin
      case (r_state)
        S_IDLE: begin
          if (i_Valid) begin
            r_ctrl <= w_dec;
            if (w_dec_seq) begin
              r_state <= S_SEQ;
              r_list  <= w_rest;
              r_offs  <= OFFS_W'(4);
              r_load  <= i_Funct[0];
              r_wb    <= w_wb_req;
            end
          end else begin
            r_ctrl <= '0;
          end
        end
        S_SEQ: begin
          r_ctrl <= w_seq;
          if (r_list != '0) begin
            r_list <= w_rest;
            r_offs <= r_offs + OFFS_W'(4);
            if ((w_rest == '0) && !r_wb) r_state <= S_IDLE;
          end else begin
            r_wb    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_Valid_E      = r_ctrl.valid;
  assign o_Reg_Write_E  = r_ctrl.reg_write;
  assign o_Mem_Write_E  = r_ctrl.mem_write;
  assign o_Mem_To_Reg_E = r_ctrl.mem_to_reg;
  assign o_ALU_Src_E    = r_ctrl.alu_src;
  assign o_Branch_E     = r_ctrl.branch;
  assign o_ALU_Op_E     = r_ctrl.alu_op;
  assign o_Reg_Src_E    = r_ctrl.reg_src;
  assign o_Imm_Src_E    = r_ctrl.imm_src;
  assign o_Uop_Reg_E    = r_ctrl.uop_reg;
  assign o_Uop_Offs_E   = r_ctrl.uop_offs;
  assign o_Uop_E        = r_ctrl.uop;
  assign o_Undef_E      = r_ctrl.undef;

endmodule

// File: tb/tb_arm_pipelined_uop_decoder.sv
// Bench for arm_pipelined_uop_decoder: directed scenarios plus randomized traffic.
// The reference model expands each accepted instruction into its full list of micro-ops up front.
// Drives on the falling edge, samples 1 time unit after the rising edge.
module tb_arm_pipelined_uop_decoder;

  logic        i_CLK = 1'b0;
  logic        i_RESET_N;
  logic        i_Valid;
  logic [1:0]  i_Op;
  logic [5:0]  i_Funct;
  logic [15:0] i_Reg_List;
  logic        i_Stall;
  logic        i_Flush;
  logic        o_Ready, o_Valid_E, o_Reg_Write_E, o_Mem_Write_E, o_Mem_To_Reg_E;
  logic        o_ALU_Src_E, o_Branch_E, o_ALU_Op_E, o_Uop_E, o_Undef_E;
  logic [1:0]  o_Reg_Src_E, o_Imm_Src_E;
  logic [3:0]  o_Uop_Reg_E;
  logic [6:0]  o_Uop_Offs_E;

  arm_pipelined_uop_decoder dut (
    .i_CLK(i_CLK), .i_RESET_N(i_RESET_N), .i_Valid(i_Valid), .i_Op(i_Op),
    .i_Funct(i_Funct), .i_Reg_List(i_Reg_List), .i_Stall(i_Stall), .i_Flush(i_Flush),
    .o_Ready(o_Ready), .o_Valid_E(o_Valid_E), .o_Reg_Write_E(o_Reg_Write_E),
    .o_Mem_Write_E(o_Mem_Write_E), .o_Mem_To_Reg_E(o_Mem_To_Reg_E),
    .o_ALU_Src_E(o_ALU_Src_E), .o_Branch_E(o_Branch_E), .o_ALU_Op_E(o_ALU_Op_E),
    .o_Reg_Src_E(o_Reg_Src_E), .o_Imm_Src_E(o_Imm_Src_E), .o_Uop_Reg_E(o_Uop_Reg_E),
    .o_Uop_Offs_E(o_Uop_Offs_E), .o_Uop_E(o_Uop_E), .o_Undef_E(o_Undef_E)
  );

  always #5 i_CLK = ~i_CLK;

  typedef struct packed {
    logic       valid, rw, mw, m2r, asrc, br, aop;
    logic [1:0] rsrc, isrc;
    logic [3:0] ureg;
    logic [6:0] uoffs;
    logic       uop, undef;
  } exp_t;

  exp_t m_exp;
  exp_t m_q[$];
  logic ready_seen, ready_exp;
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t act();
    exp_t a;
    a.valid = o_Valid_E;      a.rw = o_Reg_Write_E;  a.mw = o_Mem_Write_E;
    a.m2r = o_Mem_To_Reg_E;   a.asrc = o_ALU_Src_E;  a.br = o_Branch_E;
    a.aop = o_ALU_Op_E;       a.rsrc = o_Reg_Src_E;  a.isrc = o_Imm_Src_E;
    a.ureg = o_Uop_Reg_E;     a.uoffs = o_Uop_Offs_E;
    a.uop = o_Uop_E;          a.undef = o_Undef_E;
    return a;
  endfunction

  // Reference: list every micro-op an instruction produces, straight from the decode rules
  task automatic expand(input logic [1:0] op, input logic [5:0] f, input logic [15:0] l);
    exp_t e, u;
    int   n;
    e = '0;
    e.valid = 1'b1;
    n = 0;
    if (op == 2'd0) begin
      e.aop = 1'b1; e.asrc = f[5];
      e.rw = !(f[4] && !f[3] && f[0]);
      m_q.push_back(e);
    end else if (op == 2'd1) begin
      e.isrc = 2'd1; e.asrc = !f[5];
      if (f[0]) begin e.m2r = 1'b1; e.rw = 1'b1; end
      else begin e.mw = 1'b1; e.rsrc = 2'd2; end
      m_q.push_back(e);
    end else if (op == 2'd2 && f[5]) begin
      e.br = 1'b1; e.isrc = 2'd2; e.asrc = 1'b1; e.rsrc = 2'd1;
      m_q.push_back(e);
    end else if (op == 2'd2 && !f[4] && f[3]) begin
      for (int i = 0; i < 16; i++) begin
        if (l[i]) begin
          u = e;
          u.uop = 1'b1; u.isrc = 2'd3; u.asrc = 1'b1;
          u.ureg = 4'(i); u.uoffs = 7'(4 * n);
          if (f[0]) begin u.m2r = 1'b1; u.rw = 1'b1; end
          else begin u.mw = 1'b1; u.rsrc = 2'd2; end
          m_q.push_back(u);
          n++;
        end
      end
      if (n == 0) m_q.push_back(e);
`ifdef ARM_LDM_WRITEBACK_EN
      if (f[1] && n > 0) begin
        u = e;
        u.rw = 1'b1; u.aop = 1'b1; u.asrc = 1'b1; u.isrc = 2'd3; u.uoffs = 7'(4 * n);
        m_q.push_back(u);
      end
`endif
    end else begin
      e.undef = 1'b1;
      m_q.push_back(e);
    end
  endtask

  task automatic model_update(input logic v, input logic [1:0] op, input logic [5:0] f,
                              input logic [15:0] l, input logic st, input logic fl);
    if (fl) begin
      m_exp = '0;
      m_q.delete();
    end else if (!st) begin
      if (m_q.size() > 0) m_exp = m_q.pop_front();
      else if (v) begin
        expand(op, f, l);
        m_exp = m_q.pop_front();
      end else m_exp = '0;
    end
  endtask

  // One cycle: drive on falling edge, record ready, advance model at the rising edge
  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                       input logic [15:0] l, input logic st, input logic fl);
    @(negedge i_CLK);
    i_Valid = v; i_Op = op; i_Funct = f; i_Reg_List = l; i_Stall = st; i_Flush = fl;
    #1;
    ready_seen = o_Ready;
    ready_exp  = (m_q.size() == 0);
    @(posedge i_CLK);
    model_update(v, op, f, l, st, fl);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 6'd0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    i_RESET_N = 1'b0;
    i_Valid = 1'b0; i_Op = '0; i_Funct = '0; i_Reg_List = '0; i_Stall = 1'b0; i_Flush = 1'b0;
    m_exp = '0;
    m_q.delete();
    repeat (2) @(negedge i_CLK);
    if (act() !== exp_t'(0)) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", act());
    end
    checks++;
    i_RESET_N = 1'b1;
    idle();
    if (ready_seen !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", ready_seen);
    end
    checks++;
    if (act() !== exp_t'(0)) begin
      errors++; $display("FAIL reset_idle: got %h want 0", act());
    end
    checks++;
    // asynchronous reset in the middle of an LDM sequence
    drive(1'b1, 2'd2, 6'b001001, 16'h0025, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 6'd0, 16'd0, 1'b0, 1'b0);
    #2;
    i_RESET_N = 1'b0;
    #1;
    m_exp = '0;
    m_q.delete();
    if (act() !== exp_t'(0) || o_Ready !== 1'b1) begin
      errors++; $display("FAIL reset_midseq: got %h ready %b want 0 ready 1", act(), o_Ready);
    end
    checks++;
    @(negedge i_CLK);
    i_RESET_N = 1'b1;
    idle();
    if (act() !== exp_t'(0) || ready_seen !== 1'b1) begin
      errors++; $display("FAIL reset_after: got %h ready %b want 0 ready 1", act(), ready_seen);
    end
    checks++;
  endtask

  task automatic test_dp();
    drive(1'b1, 2'd0, 6'b101000, 16'h0, 1'b0, 1'b0);
    if (o_Reg_Write_E !== 1'b1 || o_ALU_Src_E !== 1'b1 || o_ALU_Op_E !== 1'b1 || o_Valid_E !== 1'b1) begin
      errors++; $display("FAIL dp_add: got rw %b asrc %b aop %b v %b want 1 1 1 1",
                         o_Reg_Write_E, o_ALU_Src_E, o_ALU_Op_E, o_Valid_E);
    end
    checks++;
    drive(1'b1, 2'd0, 6'b010101, 16'h0, 1'b0, 1'b0);
    if (o_Reg_Write_E !== 1'b0 || act() !== m_exp) begin
      errors++; $display("FAIL dp_cmp: got %h want %h", act(), m_exp);
    end
    checks++;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'(i % 3), 6'($urandom), 16'h0, 1'b0, 1'b0);
      if (act() !== m_exp) begin
        errors++; $display("FAIL decode_%0d: got %h want %h", i, act(), m_exp);
      end
      checks++;
    end
    idle();
  endtask

  task automatic test_ldm();
    logic [3:0] regs [3];
    logic [6:0] offs [3];
    regs[0] = 4'd0; regs[1] = 4'd2; regs[2] = 4'd5;
    offs[0] = 7'd0; offs[1] = 7'd4; offs[2] = 7'd8;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(1'b1, 2'd2, 6'b001001, 16'h0025, 1'b0, 1'b0);
      else        drive(1'b1, 2'd0, 6'b101000, 16'h0, 1'b0, 1'b0);
      if (act() !== m_exp || o_Uop_Reg_E !== regs[i] || o_Uop_Offs_E !== offs[i] || o_Uop_E !== 1'b1) begin
        errors++; $display("FAIL ldm_uop%0d: got %h want %h reg %0d offs %0d", i, act(), m_exp, regs[i], offs[i]);
      end
      checks++;
      if (ready_seen !== (i == 0)) begin
        errors++; $display("FAIL ldm_ready%0d: got %b want %b", i, ready_seen, i == 0);
      end
      checks++;
    end
    idle();
    if (ready_seen !== 1'b1 || o_Valid_E !== 1'b0) begin
      errors++; $display("FAIL ldm_done: ready %b valid %b want 1 0", ready_seen, o_Valid_E);
    end
    checks++;
  endtask

  task automatic test_stall();
    drive(1'b1, 2'd2, 6'b001001, 16'h0025, 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 2'd0, 6'd0, 16'd0, 1'b1, 1'b0);
      if (act() !== m_exp || o_Uop_Reg_E !== 4'd2 || o_Uop_Offs_E !== 7'd4) begin
        errors++; $display("FAIL stall_hold%0d: got %h want %h", i, act(), m_exp);
      end
      checks++;
    end
    idle();
    if (act() !== m_exp || o_Uop_Reg_E !== 4'd5 || o_Uop_Offs_E !== 7'd8) begin
      errors++; $display("FAIL stall_resume: got %h want %h", act(), m_exp);
    end
    checks++;
    idle();
  endtask

  task automatic test_flush();
    drive(1'b1, 2'd2, 6'b001000, 16'h00F0, 1'b0, 1'b0);
    if (act() !== m_exp || o_Mem_Write_E !== 1'b1 || o_Uop_Reg_E !== 4'd4) begin
      errors++; $display("FAIL stm_first: got %h want %h", act(), m_exp);
    end
    checks++;
    drive(1'b0, 2'd0, 6'd0, 16'd0, 1'b0, 1'b1);
    if (o_Valid_E !== 1'b0 || o_Ready !== 1'b1 || act() !== m_exp) begin
      errors++; $display("FAIL flush: got %h ready %b want %h ready 1", act(), o_Ready, m_exp);
    end
    checks++;
    for (int i = 0; i < 3; i++) begin
      idle();
      if (o_Valid_E !== 1'b0) begin
        errors++; $display("FAIL flush_drain%0d: valid %b want 0", i, o_Valid_E);
      end
      checks++;
    end
  endtask

  task automatic test_edge_cases();
    logic [5:0] fs [4];
    logic [1:0] ops [4];
    logic [15:0] ls [4];
    ops[0] = 2'd3; fs[0] = 6'b000001; ls[0] = 16'h0000;   // Op=11
    ops[1] = 2'd2; fs[1] = 6'b011001; ls[1] = 16'h0003;   // P=1
    ops[2] = 2'd2; fs[2] = 6'b001001; ls[2] = 16'h8000;   // k=1
    ops[3] = 2'd2; fs[3] = 6'b001000; ls[3] = 16'h0000;   // k=0
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ops[i], fs[i], ls[i], 1'b0, 1'b0);
      if (act() !== m_exp || o_Valid_E !== 1'b1 || o_Reg_Write_E !== 1'b0 && i != 2) begin
        errors++; $display("FAIL edge%0d: got %h want %h", i, act(), m_exp);
      end
      checks++;
      idle();
      if (ready_seen !== 1'b1 || o_Valid_E !== 1'b0) begin
        errors++; $display("FAIL edge%0d_idle: ready %b valid %b want 1 0", i, ready_seen, o_Valid_E);
      end
      checks++;
    end
`ifdef ARM_LDM_WRITEBACK_EN
    drive(1'b1, 2'd2, 6'b001011, 16'h0003, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) idle();
      if (act() !== m_exp) begin
        errors++; $display("FAIL wb_uop%0d: got %h want %h", i, act(), m_exp);
      end
      checks++;
    end
    if (o_Uop_Offs_E !== 7'd8 || o_Reg_Write_E !== 1'b1 || o_Uop_E !== 1'b0) begin
      errors++; $display("FAIL wb_final: offs %0d rw %b uop %b want 8 1 0", o_Uop_Offs_E, o_Reg_Write_E, o_Uop_E);
    end
    checks++;
    idle();
`endif
  endtask

  task automatic test_random();
    logic [5:0]  f;
    logic [15:0] l;
    for (int i = 0; i < 400; i++) begin
      f = 6'($urandom);
      if ($urandom_range(0, 1) == 0) f[4:3] = 2'b01;
      l = 16'($urandom & $urandom);
      if ($urandom_range(0, 7) == 0) l = 16'h0;
      drive($urandom_range(0, 3) != 0, 2'($urandom), f, l,
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      if (act() !== m_exp) begin
        errors++; $display("FAIL rand_out%0d: got %h want %h", i, act(), m_exp);
      end
      checks++;
      if (ready_seen !== ready_exp) begin
        errors++; $display("FAIL rand_ready%0d: got %b want %b", i, ready_seen, ready_exp);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_dp();
    test_ldm();
    test_stall();
    test_flush();
    test_edge_cases();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
